// File: rtl/seven_segment_pkg.sv
// Shared seven-segment constants: active-low {g..a} hex patterns, bit positions and the blank code.
// Used by the display driver side and by the scan decoder.
package seven_segment_pkg;

   typedef logic [6:0] seg_pattern_t;

   localparam int SEG_A_BIT  = 0;
   localparam int SEG_G_BIT  = 6;
   localparam int SEG_DP_BIT = 7;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low {g,f,e,d,c,b,a}: a 0 bit means the segment is lit.
   localparam seg_pattern_t SEG_0 = 7'b1000000;
   localparam seg_pattern_t SEG_1 = 7'b1111001;
   localparam seg_pattern_t SEG_2 = 7'b0100100;
   localparam seg_pattern_t SEG_3 = 7'b0110000;
   localparam seg_pattern_t SEG_4 = 7'b0011001;
   localparam seg_pattern_t SEG_5 = 7'b0010010;
   localparam seg_pattern_t SEG_6 = 7'b0000010;
   localparam seg_pattern_t SEG_7 = 7'b1111000;
   localparam seg_pattern_t SEG_8 = 7'b0000000;
   localparam seg_pattern_t SEG_9 = 7'b0010000;
   localparam seg_pattern_t SEG_A = 7'b0001000;
   localparam seg_pattern_t SEG_B = 7'b0000011;
   localparam seg_pattern_t SEG_C = 7'b1000110;
   localparam seg_pattern_t SEG_D = 7'b0100001;
   localparam seg_pattern_t SEG_E = 7'b0000110;
   localparam seg_pattern_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seven_segment_pattern_to_hex.sv
// Combinational lookup from an active-low {g..a} segment pattern to its hex digit.
// Anything outside the sixteen hex glyphs reports legal = 0.
module seven_segment_pattern_to_hex
   import seven_segment_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       legal,
   output logic [3:0] hex
);

   always_comb begin
      legal = 1'b1;
      hex   = 4'h0;
      case (pattern)
         SEG_0:   hex = 4'h0;
         SEG_1:   hex = 4'h1;
         SEG_2:   hex = 4'h2;
         SEG_3:   hex = 4'h3;
         SEG_4:   hex = 4'h4;
         SEG_5:   hex = 4'h5;
         SEG_6:   hex = 4'h6;
         SEG_7:   hex = 4'h7;
         SEG_8:   hex = 4'h8;
         SEG_9:   hex = 4'h9;
         SEG_A:   hex = 4'hA;
         SEG_B:   hex = 4'hB;
         SEG_C:   hex = 4'hC;
         SEG_D:   hex = 4'hD;
         SEG_E:   hex = 4'hE;
         SEG_F:   hex = 4'hF;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Passive reader of a multiplexed active-low seven-segment bus: recovers per-digit hex/dp after a dwell filter.
// Optional per-digit refresh timeout is enabled with `define SEVEN_SEG_BLANK_TIMEOUT_EN.
module seven_segment_scan_decoder
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DIGITS-1:0]         an_in,
   input  logic [7:0]                    seg_in,
   output logic [4*NUM_DIGITS-1:0]       hex_out,
   output logic [NUM_DIGITS-1:0]         dp_out,
   output logic [NUM_DIGITS-1:0]         digit_valid,
   output logic                          update_pulse,
   output logic [$clog2(NUM_DIGITS)-1:0] update_idx,
   output logic                          pattern_err,
   output logic                          multi_an_err
);

   localparam int         IDX_W    = $clog2(NUM_DIGITS);
   localparam int         SAMPLE_W = NUM_DIGITS + 8;
   localparam logic [7:0] STABLE   = 8'(STABLE_CYCLES);

   if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("seven_segment_scan_decoder: STABLE_CYCLES must be 1..255 and TIMEOUT_CYCLES >= 1");
   end

   logic [SAMPLE_W-1:0]   sample_q;
   logic [SAMPLE_W-1:0]   prev_q;
   logic [7:0]            dwell_q;
   logic [7:0]            dwell_next;
   logic                  committed_q;
   logic                  changed;
   logic                  commit_now;
   logic [NUM_DIGITS-1:0] an_low;
   logic                  any_low;
   logic                  multi_low;
   logic [IDX_W-1:0]      low_idx;
   logic                  pattern_legal;
   logic [3:0]            pattern_hex;

`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
   localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
   logic [TMO_W-1:0] idle_q [NUM_DIGITS];
`endif

   assign an_low  = ~sample_q[SAMPLE_W-1:8];
   assign changed = (sample_q != prev_q);

   // One commit per dwell: fire only on the cycle the count first lands on STABLE.
   always_comb begin
      dwell_next = dwell_q;
      if (changed) begin
         dwell_next = 8'd1;
      end else if (dwell_q < STABLE) begin
         dwell_next = dwell_q + 8'd1;
      end
      commit_now = (dwell_next == STABLE) && (changed || !committed_q);
   end

   always_comb begin
      any_low   = 1'b0;
      multi_low = 1'b0;
      low_idx   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an_low[i]) begin
            multi_low = multi_low | any_low;
            any_low   = 1'b1;
            low_idx   = IDX_W'(i);
         end
      end
   end

   seven_segment_pattern_to_hex u_pattern_to_hex (
      .pattern (sample_q[SEG_G_BIT:SEG_A_BIT]),
      .legal   (pattern_legal),
      .hex     (pattern_hex)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_q     <= {{NUM_DIGITS{1'b1}}, SEG_BLANK};
         prev_q       <= {{NUM_DIGITS{1'b1}}, SEG_BLANK};
         dwell_q      <= '0;
         committed_q  <= 1'b0;
         hex_out      <= '0;
         dp_out       <= '0;
         digit_valid  <= '0;
         update_pulse <= 1'b0;
         update_idx   <= '0;
         pattern_err  <= 1'b0;
         multi_an_err <= 1'b0;
`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
         for (int i = 0; i < NUM_DIGITS; i++) begin
            idle_q[i] <= '0;
         end
`endif
      end else begin
         sample_q     <= {an_in, seg_in};
         prev_q       <= sample_q;
         dwell_q      <= dwell_next;
         committed_q  <= commit_now | (committed_q & ~changed);
         update_pulse <= 1'b0;
         pattern_err  <= 1'b0;
         multi_an_err <= 1'b0;

`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
         // Idle counters saturate at the timeout; a commit below takes priority over expiry.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idle_q[i] != TMO_MAX) begin
               idle_q[i] <= idle_q[i] + TMO_W'(1);
               if (idle_q[i] == TMO_MAX - TMO_W'(1)) begin
                  digit_valid[i] <= 1'b0;
               end
            end
         end
`endif

         if (commit_now) begin
            if (multi_low) begin
               multi_an_err <= 1'b1;
               update_idx   <= '0;
            end else if (any_low) begin
               update_idx <= low_idx;
               if (pattern_legal) begin
                  hex_out[4*int'(low_idx) +: 4] <= pattern_hex;
                  dp_out[low_idx]               <= ~sample_q[SEG_DP_BIT];
                  digit_valid[low_idx]          <= 1'b1;
                  update_pulse                  <= 1'b1;
`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
                  idle_q[low_idx]               <= '0;
`endif
               end else begin
                  digit_valid[low_idx] <= 1'b0;
                  pattern_err          <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Self-checking bench for seven_segment_scan_decoder: directed scenarios plus random dwells against a dwell-run model.
// Define SEVEN_SEG_BLANK_TIMEOUT_EN to also exercise the refresh timeout (TIMEOUT_CYCLES = 50).
module tb_seven_segment_scan_decoder;

   localparam int ND     = 8;
   localparam int STABLE = 4;
   localparam int TMO    = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  an_in = 8'hFF;
   logic [7:0]  seg_in = 8'hFF;
   logic [31:0] hex_out;
   logic [7:0]  dp_out;
   logic [7:0]  digit_valid;
   logic        update_pulse;
   logic [2:0]  update_idx;
   logic        pattern_err;
   logic        multi_an_err;

   int checks = 0;
   int fails  = 0;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Reference state: what the display should read back, derived from runs of identical bus values.
   logic [31:0] exp_hex;
   logic [7:0]  exp_dp;
   logic [7:0]  exp_valid;
   logic        exp_pulse;
   logic        exp_perr;
   logic        exp_merr;
   logic [2:0]  exp_idx;
   logic [15:0] run_val;
   logic [15:0] pend_val;
   int          run_len;
   bit          pend;
   int          obs_pulse;
   int          obs_perr;
   int          obs_merr;
`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
   int          age [ND];
`endif

   seven_segment_scan_decoder #(
      .NUM_DIGITS     (ND),
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .an_in        (an_in),
      .seg_in       (seg_in),
      .hex_out      (hex_out),
      .dp_out       (dp_out),
      .digit_valid  (digit_valid),
      .update_pulse (update_pulse),
      .update_idx   (update_idx),
      .pattern_err  (pattern_err),
      .multi_an_err (multi_an_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      exp_hex   = '0;
      exp_dp    = '0;
      exp_valid = '0;
      exp_pulse = 1'b0;
      exp_perr  = 1'b0;
      exp_merr  = 1'b0;
      exp_idx   = '0;
      run_val   = '1;
      run_len   = 0;
      pend      = 1'b0;
      obs_pulse = 0;
      obs_perr  = 0;
      obs_merr  = 0;
`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
      for (int i = 0; i < ND; i++) age[i] = 0;
`endif
   endtask

   task automatic model_commit(input logic [15:0] v);
      int lows;
      int k;
      int found;
      lows  = 0;
      k     = 0;
      found = -1;
      for (int i = 0; i < ND; i++) begin
         if (!v[8+i]) begin
            lows++;
            k = i;
         end
      end
      if (lows > 1) begin
         exp_merr = 1'b1;
         exp_idx  = '0;
      end else if (lows == 1) begin
         exp_idx = 3'(k);
         for (int j = 0; j < 16; j++) if (seg_tab[j] == v[6:0]) found = j;
         if (found >= 0) begin
            exp_hex[4*k +: 4] = 4'(found);
            exp_dp[k]         = ~v[7];
            exp_valid[k]      = 1'b1;
            exp_pulse         = 1'b1;
`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
            age[k] = 0;
`endif
         end else begin
            exp_valid[k] = 1'b0;
            exp_perr     = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      an_in  = 8'hFF;
      seg_in = 8'hFF;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Drive one clock of bus value; a run reaching STABLE samples takes effect one edge later.
   task automatic step(input logic [7:0] an, input logic [7:0] seg);
      an_in  = an;
      seg_in = seg;
      @(posedge clk);
      #1;
      exp_pulse = 1'b0;
      exp_perr  = 1'b0;
      exp_merr  = 1'b0;
`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
      for (int i = 0; i < ND; i++) begin
         if (age[i] < TMO) begin
            age[i]++;
            if (age[i] == TMO) exp_valid[i] = 1'b0;
         end
      end
`endif
      if (pend) begin
         model_commit(pend_val);
         pend = 1'b0;
      end
      if (run_len > 0 && {an, seg} == run_val) begin
         if (run_len < 1000) run_len++;
      end else begin
         run_val = {an, seg};
         run_len = 1;
      end
      if (run_len == STABLE) begin
         pend     = 1'b1;
         pend_val = run_val;
      end
      if (update_pulse) obs_pulse++;
      if (pattern_err)  obs_perr++;
      if (multi_an_err) obs_merr++;
   endtask

   function automatic logic [15:0] rand_value();
      int         r;
      int         k1;
      int         k2;
      logic [6:0] p;
      logic [7:0] an;
      logic [7:0] seg;
      r  = int'($urandom_range(0, 9));
      k1 = int'($urandom_range(0, ND-1));
      an  = ~(8'b1 << k1);
      seg = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
      if (r == 6) begin
         p = 7'($urandom);
         for (int j = 0; j < 16; j++) if (seg_tab[j] == p) p = 7'h7F;
         seg = {1'($urandom), p};
      end else if (r == 7) begin
         an = 8'hFF;
      end else if (r == 8) begin
         k2 = (k1 + int'($urandom_range(1, ND-1))) % ND;
         an = ~((8'b1 << k1) | (8'b1 << k2));
      end else if (r == 9) begin
         an  = 8'($urandom);
         seg = 8'($urandom);
      end
      return {an, seg};
   endfunction

   task automatic test_reset();
      an_in  = 8'h00;
      seg_in = 8'h00;
      rst    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (hex_out !== 32'h0 || dp_out !== 8'h0) begin
         fails++;
         $display("[TB] FAIL reset_hex_dp: got hex=%h dp=%h, expected 0", hex_out, dp_out);
      end
      checks++;
      if (digit_valid !== 8'h0) begin
         fails++;
         $display("[TB] FAIL reset_valid: got %h, expected 00", digit_valid);
      end
      checks++;
      if ({update_pulse, pattern_err, multi_an_err, update_idx} !== 6'b0) begin
         fails++;
         $display("[TB] FAIL reset_strobes: got %b, expected 000000",
                  {update_pulse, pattern_err, multi_an_err, update_idx});
      end
      do_reset();
   endtask

   task automatic test_first_commit();
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         step(8'b11111110, 8'b10100100);
         checks++;
         if (update_pulse !== (c == STABLE + 1)) begin
            fails++;
            $display("[TB] FAIL first_pulse clk %0d: got %b, expected %b", c, update_pulse, (c == STABLE + 1));
         end
      end
      checks++;
      if (hex_out[3:0] !== 4'h2 || dp_out[0] !== 1'b0 || update_idx !== 3'd0) begin
         fails++;
         $display("[TB] FAIL first_value: got hex=%h dp=%b idx=%0d, expected 2 0 0", hex_out[3:0], dp_out[0], update_idx);
      end
      checks++;
      if (digit_valid !== 8'h01) begin
         fails++;
         $display("[TB] FAIL first_valid: got %h, expected 01", digit_valid);
      end
   endtask

   task automatic test_scan();
      obs_pulse = 0;
      obs_perr  = 0;
      obs_merr  = 0;
      for (int d = 0; d < ND; d++) begin
         repeat (10) step(~(8'b1 << d), {1'b1, seg_tab[d]});
         repeat (2) step(8'hFF, 8'hFF);
      end
      checks++;
      if (obs_pulse != 8 || obs_perr != 0 || obs_merr != 0) begin
         fails++;
         $display("[TB] FAIL scan_counts: got pulses=%0d perr=%0d merr=%0d, expected 8 0 0", obs_pulse, obs_perr, obs_merr);
      end
      checks++;
      if (hex_out !== 32'h76543210 || dp_out !== 8'h00) begin
         fails++;
         $display("[TB] FAIL scan_hex: got %h dp=%h, expected 76543210 dp=00", hex_out, dp_out);
      end
      checks++;
      if (digit_valid !== exp_valid) begin
         fails++;
         $display("[TB] FAIL scan_valid: got %h, expected %h", digit_valid, exp_valid);
      end
`ifndef SEVEN_SEG_BLANK_TIMEOUT_EN
      checks++;
      if (digit_valid !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL scan_valid_all: got %h, expected ff", digit_valid);
      end
`endif
   endtask

   task automatic test_pattern_err();
      logic [7:0] valid_before;
      valid_before = exp_valid;
      obs_pulse = 0;
      obs_perr  = 0;
      repeat (5) step(8'b11110111, 8'b11111111);
      checks++;
      if (obs_perr != 1 || obs_pulse != 0 || update_idx !== 3'd3) begin
         fails++;
         $display("[TB] FAIL perr_strobe: got perr=%0d pulses=%0d idx=%0d, expected 1 0 3", obs_perr, obs_pulse, update_idx);
      end
      checks++;
      if (digit_valid !== (valid_before & 8'hF7) || hex_out !== 32'h76543210) begin
         fails++;
         $display("[TB] FAIL perr_state: got valid=%h hex=%h, expected %h 76543210", digit_valid, hex_out, valid_before & 8'hF7);
      end
   endtask

   task automatic test_multi_anode();
      logic [7:0] valid_before;
      valid_before = exp_valid;
      obs_pulse = 0;
      obs_merr  = 0;
      repeat (5) step(8'b11111100, {1'b1, seg_tab[5]});
      checks++;
      if (obs_merr != 1 || obs_pulse != 0 || update_idx !== 3'd0) begin
         fails++;
         $display("[TB] FAIL multi_strobe: got merr=%0d pulses=%0d idx=%0d, expected 1 0 0", obs_merr, obs_pulse, update_idx);
      end
      checks++;
      if (digit_valid !== valid_before || hex_out !== 32'h76543210) begin
         fails++;
         $display("[TB] FAIL multi_state: got valid=%h hex=%h, expected %h 76543210", digit_valid, hex_out, valid_before);
      end
   endtask

   task automatic test_glitch_and_reset();
      obs_pulse = 0;
      repeat (3) step(8'b11111101, 8'h90);
      repeat (5) step(8'hFF, 8'hFF);
      checks++;
      if (obs_pulse != 0 || hex_out[7:4] !== 4'h1) begin
         fails++;
         $display("[TB] FAIL ghost_filter: got pulses=%0d digit1=%h, expected 0 1", obs_pulse, hex_out[7:4]);
      end
      repeat (2) step(8'b11111101, 8'h90);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({hex_out, dp_out, digit_valid, update_pulse, update_idx, pattern_err, multi_an_err} !== '0) begin
         fails++;
         $display("[TB] FAIL midreset_clear: got hex=%h dp=%h valid=%h, expected all 0", hex_out, dp_out, digit_valid);
      end
      #1;
      rst = 1'b0;
      model_reset();
      for (int c = 1; c <= 6; c++) begin
         step(8'b11111101, 8'h90);
         checks++;
         if (update_pulse !== (c == STABLE + 1)) begin
            fails++;
            $display("[TB] FAIL post_reset_pulse clk %0d: got %b, expected %b", c, update_pulse, (c == STABLE + 1));
         end
      end
      checks++;
      if (hex_out !== 32'h00000090 || digit_valid !== 8'h02) begin
         fails++;
         $display("[TB] FAIL post_reset_value: got hex=%h valid=%h, expected 00000090 02", hex_out, digit_valid);
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      int          len;
      int          n;
      do_reset();
      n = 0;
      for (int t = 0; t < 250; t++) begin
         v   = rand_value();
         len = int'($urandom_range(1, 7));
         for (int c = 0; c < len; c++) begin
            step(v[15:8], v[7:0]);
            n++;
            checks++;
            if (hex_out !== exp_hex) begin
               fails++;
               $display("[TB] FAIL rand_hex cycle %0d: got %h, expected %h", n, hex_out, exp_hex);
            end
            checks++;
            if ({dp_out, digit_valid} !== {exp_dp, exp_valid}) begin
               fails++;
               $display("[TB] FAIL rand_dp_valid cycle %0d: got %h, expected %h", n, {dp_out, digit_valid}, {exp_dp, exp_valid});
            end
            checks++;
            if ({update_pulse, pattern_err, multi_an_err} !== {exp_pulse, exp_perr, exp_merr}) begin
               fails++;
               $display("[TB] FAIL rand_strobes cycle %0d: got %b, expected %b", n,
                        {update_pulse, pattern_err, multi_an_err}, {exp_pulse, exp_perr, exp_merr});
            end
            checks++;
            if (update_idx !== exp_idx) begin
               fails++;
               $display("[TB] FAIL rand_idx cycle %0d: got %0d, expected %0d", n, update_idx, exp_idx);
            end
         end
      end
   endtask

`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      repeat (5) step(8'b11111101, {1'b1, seg_tab[1]});
      checks++;
      if (update_pulse !== 1'b1 || digit_valid[1] !== 1'b1) begin
         fails++;
         $display("[TB] FAIL tmo_commit: got pulse=%b valid1=%b, expected 1 1", update_pulse, digit_valid[1]);
      end
      for (int j = 1; j <= TMO + 1; j++) begin
         step(8'hFF, 8'hFF);
         checks++;
         if (digit_valid[1] !== (j < TMO)) begin
            fails++;
            $display("[TB] FAIL tmo_valid clk %0d after commit: got %b, expected %b", j, digit_valid[1], (j < TMO));
         end
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_first_commit();
      test_scan();
      test_pattern_err();
      test_multi_anode();
      test_glitch_and_reset();
      test_random();
`ifdef SEVEN_SEG_BLANK_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Reader end of the seven-segment display interface: passively samples a time-multiplexed, active-low display bus (digit anodes plus segment pattern).
- Recovers, per digit, the 4-bit hex value and decimal point being shown.
- Used by on-board self-check and by the clock test bench to confirm what the display driver actually puts on the pins.
- Qualifies each pattern by dwell time, flags undecodable patterns and bus faults.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (anode lines)
STABLE_CYCLES, 4, consecutive identical samples needed to commit a digit (min 1, max 255)
TIMEOUT_CYCLES, 1000000, refresh timeout in clocks (used only with BLANK_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
an_in  input  NUM_DIGITS  digit enables, active-low, bit i = digit i
seg_in  input  8  segment pattern, active-low, {dp,g,f,e,d,c,b,a}
hex_out  output  4*NUM_DIGITS  recovered hex; digit i in bits [4i+3:4i]
dp_out  output  NUM_DIGITS  recovered decimal point per digit, 1 = lit
digit_valid  output  NUM_DIGITS  1 = digit i holds a committed legal value
update_pulse  output  1  one-cycle strobe on each commit
update_idx  output  $clog2(NUM_DIGITS)  digit index of the current commit/error
pattern_err  output  1  one-cycle strobe: stable pattern not in hex table
multi_an_err  output  1  one-cycle strobe: more than one anode low and stable

Behaviour:
- Reset (async, active-high): all outputs 0, sample register = all-ones (blank), dwell counter 0, committed flag 0.
- Cycle 0: {an_in, seg_in} registered into the sample register.
- Dwell counter: loads 1 when the sample differs from the previous sample; otherwise increments, saturating at STABLE_CYCLES.
- Commit point: the cycle the counter first reaches STABLE_CYCLES. Exactly one commit per dwell; the committed flag is held until the sample changes.
- Latency: outputs update STABLE_CYCLES+1 clocks after an input change that is then held.
- Commit action, when exactly one anode is low (index k):
  - Legal pattern: hex_out[k], dp_out[k] = ~seg_in[7] and digit_valid[k]=1 update; update_pulse=1; update_idx=k.
  - Illegal pattern: digit_valid[k]=0; hex_out[k] unchanged; pattern_err=1; update_idx=k.
- Legal patterns on {g..a}, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. dp is ignored for legality.
- All anodes high (blanking gap): no commit, no error; digit state retained.
- Two or more anodes low at commit point: multi_an_err=1, no digit updated, update_idx=0.
- Same pattern re-shown on a later scan: recommits normally. A dwell shorter than STABLE_CYCLES never commits; this is the ghosting filter.
- Reset mid-dwell: counter and all outputs clear immediately; the next valid dwell must complete STABLE_CYCLES from scratch.

Optional Feature:
- SEVEN_SEG_BLANK_TIMEOUT_EN defined:
  - Per-digit counter cleared on each commit for that digit.
  - On reaching TIMEOUT_CYCLES, digit_valid[i] clears and the counter holds until the next commit.
- Undefined: digit_valid stays set indefinitely after a legal commit; no timeout counters synthesized.

Decomposition:
- Package seven_segment_pkg:
  - SEG_0..SEG_F pattern constants.
  - SEG_DP_BIT=7 and the {dp,g..a} bit-position constants.
  - SEG_BLANK = 8'hFF.
  - Shared by the existing display decoder and this block.
- Sub-module seven_segment_pattern_to_hex: combinational 7-bit pattern to {legal, hex[3:0]} lookup, instantiated once on the sample register.

Test Plan:
- Reset, then hold an_in=8'b11111110, seg_in=8'b10100100 for 6 clk → one update_pulse 5 clk after change, update_idx=0, hex_out[3:0]=2, dp_out[0]=0, digit_valid=8'h01.
- Scan digits 0..7 with patterns 0..7, 10 clk each, 2-clk blank gaps → 8 pulses, hex_out=32'h76543210, digit_valid=8'hFF, no errors.
- an_in=8'b11110111, seg_in=8'b11111111 (no segments lit) held 5 clk → pattern_err once, update_idx=3, digit_valid[3]=0.
- an_in=8'b11111100 held 5 clk → multi_an_err once, no digit_valid change.
- Glitch: pattern held 3 clk (STABLE_CYCLES=4) then changed → no pulse; assert rst mid-dwell → all outputs 0 within the same cycle.
- With SEVEN_SEG_BLANK_TIMEOUT_EN and TIMEOUT_CYCLES=50: commit digit 1, then blank 51 clk → digit_valid[1] falls at clk 50 after commit.
